data_mem_responder: RTL and testbench

- Memory-side responder for the cache-to-memory interface: accepts one read or write request at a time from the cache, models a fixed access latency, then returns a single-cycle response.
- Sits between the data cache and the backing store in the memory stage.
- Supports word and byte accesses on a little-endian, byte-addressed storage array.

---
 rtl/data_mem_responder.sv | 151 +++++++++++++++
 tb/tb_data_mem_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Memory-side responder: one cache read/write at a time against a byte-addressed little-endian array.
// valid_o pulses `latency` cycles after accept; while busy ready_o is low and all request inputs are ignored.
module data_mem_responder #(
  parameter int width     = 32,
  parameter int addr_bits = 10,
  parameter int latency   = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  input  logic             write_enable_i,
  input  logic             byte_op_i,
  input  logic [width-1:0] address_i,
  input  logic [width-1:0] write_data_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [width-1:0] read_data_o
);

  typedef enum logic [1:0] {
    RST_EXIT = 2'd0,
    IDLE     = 2'd1,
    WAIT     = 2'd2,
    RESP     = 2'd3
  } state_t;

  localparam logic [3:0] cnt_load = (latency >= 2) ? 4'(latency - 2) : 4'd0;
  localparam int mem_bytes = 1 << addr_bits;

  state_t state;
  state_t next_state;

  logic [3:0]           cnt;
  logic [addr_bits-1:0] cap_addr;
  logic [31:0]          cap_wdata;
  logic                 cap_we;
  logic                 cap_byte;

  logic                 accept;
  logic                 enter_resp;
  logic [addr_bits-1:0] acc_addr;
  logic [31:0]          acc_wdata;
  logic                 acc_we;
  logic                 acc_byte;
  logic [addr_bits-1:0] word_idx [4];

  logic [7:0] mem [mem_bytes];

  // Address bits above the decoded range alias onto the array.
  logic unused_addr_hi;
  assign unused_addr_hi = ^address_i[width-1:addr_bits];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= RST_EXIT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      RST_EXIT: next_state = IDLE;
      IDLE: begin
        if (req_i) begin
          next_state = (latency == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          next_state = RESP;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = RST_EXIT;
    endcase
  end

  always_comb begin
    ready_o    = (state == IDLE);
    valid_o    = (state == RESP);
    accept     = (state == IDLE) && req_i;
    enter_resp = (next_state == RESP) && (state != RESP);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt       <= 4'd0;
      cap_addr  <= '0;
      cap_wdata <= 32'd0;
      cap_we    <= 1'b0;
      cap_byte  <= 1'b0;
    end else if (accept) begin
      cnt       <= cnt_load;
      cap_addr  <= address_i[addr_bits-1:0];
      cap_wdata <= write_data_i[31:0];
      cap_we    <= write_enable_i;
      cap_byte  <= byte_op_i;
    end else if ((state == WAIT) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // With latency 1 the access edge is the accept edge, so the live inputs stand in for the captured copy.
  always_comb begin
    if (state == IDLE) begin
      acc_addr  = address_i[addr_bits-1:0];
      acc_wdata = write_data_i[31:0];
      acc_we    = write_enable_i;
      acc_byte  = byte_op_i;
    end else begin
      acc_addr  = cap_addr;
      acc_wdata = cap_wdata;
      acc_we    = cap_we;
      acc_byte  = cap_byte;
    end
    for (int i = 0; i < 4; i++) begin
      word_idx[i] = {acc_addr[addr_bits-1:2], 2'(i)};
    end
  end

  // Storage is deliberately outside the reset domain; contents survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (enter_resp && acc_we) begin
      if (acc_byte) begin
        mem[acc_addr] <= acc_wdata[7:0];
      end else begin
        for (int i = 0; i < 4; i++) begin
          mem[word_idx[i]] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      read_data_o <= '0;
    end else if (enter_resp) begin
      if (acc_we) begin
        read_data_o <= '0;
      end else if (acc_byte) begin
        read_data_o <= width'(mem[acc_addr]);
      end else begin
        read_data_o <= width'({mem[word_idx[3]], mem[word_idx[2]],
                               mem[word_idx[1]], mem[word_idx[0]]});
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus randomized checks of data_mem_responder at latency 2 and latency 1 against a byte-array model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst2_n = 1'b1;
  logic        rst1_n = 1'b1;
  logic        req2 = 1'b0;
  logic        req1 = 1'b0;
  logic        we = 1'b0;
  logic        byte_op = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;

  logic        ready2, valid2, ready1, valid1;
  logic [31:0] read_data2, read_data1;

  int errors = 0;
  int checks = 0;

  logic [7:0] model [2][1024];

  always #5 clk = ~clk;

  data_mem_responder #(.width(32), .addr_bits(10), .latency(2)) dut2 (
    .clk_i(clk), .rst_ni(rst2_n), .req_i(req2), .write_enable_i(we),
    .byte_op_i(byte_op), .address_i(addr), .write_data_i(wdata),
    .ready_o(ready2), .valid_o(valid2), .read_data_o(read_data2)
  );

  data_mem_responder #(.width(32), .addr_bits(10), .latency(1)) dut1 (
    .clk_i(clk), .rst_ni(rst1_n), .req_i(req1), .write_enable_i(we),
    .byte_op_i(byte_op), .address_i(addr), .write_data_i(wdata),
    .ready_o(ready1), .valid_o(valid1), .read_data_o(read_data1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int w);
    return (w == 0) ? ready2 : ready1;
  endfunction

  function automatic logic vld(input int w);
    return (w == 0) ? valid2 : valid1;
  endfunction

  function automatic logic [31:0] rdat(input int w);
    return (w == 0) ? read_data2 : read_data1;
  endfunction

  function automatic logic [31:0] model_read(input int w, input logic bo, input logic [31:0] a);
    int b;
    int base;
    b = int'(a % 1024);
    base = b - (b % 4);
    if (bo) return {24'd0, model[w][b]};
    return {model[w][base + 3], model[w][base + 2], model[w][base + 1], model[w][base]};
  endfunction

  task automatic model_write(input int w, input logic bo, input logic [31:0] a, input logic [31:0] d);
    int b;
    int base;
    b = int'(a % 1024);
    base = b - (b % 4);
    if (bo) begin
      model[w][b] = d[7:0];
    end else begin
      model[w][base]     = d[7:0];
      model[w][base + 1] = d[15:8];
      model[w][base + 2] = d[23:16];
      model[w][base + 3] = d[31:24];
    end
  endtask

  // One full transaction on instance w (0 = latency 2, 1 = latency 1), checked end to end.
  task automatic txn(input int w, input logic we_v, input logic bo_v,
                     input logic [31:0] a, input logic [31:0] d, input string tag);
    int waited;
    int k;
    int lat;
    logic [31:0] exp;
    lat = (w == 0) ? 2 : 1;
    waited = 0;
    while (!rdy(w) && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, " ready before accept"}, 32'(rdy(w)), 32'd1);
    we = we_v;
    byte_op = bo_v;
    addr = a;
    wdata = d;
    if (w == 0) req2 = 1'b1; else req1 = 1'b1;
    if (we_v) begin
      model_write(w, bo_v, a, d);
      exp = 32'd0;
    end else begin
      exp = model_read(w, bo_v, a);
    end
    tick();
    req2 = 1'b0;
    req1 = 1'b0;
    check({tag, " ready low after accept"}, 32'(rdy(w)), 32'd0);
    k = 0;
    while (!vld(w) && k < 20) begin
      tick();
      k++;
    end
    check({tag, " response delay"}, 32'(k), 32'(lat - 1));
    check({tag, " read_data"}, rdat(w), exp);
    tick();
    check({tag, " valid single cycle"}, 32'(vld(w)), 32'd0);
    check({tag, " ready after resp"}, 32'(rdy(w)), 32'd1);
    check({tag, " read_data hold"}, rdat(w), exp);
  endtask

  initial begin
    logic [31:0] exp;
    logic [31:0] ra;
    logic        rwe;
    logic        rbo;

    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 1024; i++) model[w][i] = 8'd0;
    end

    // Reset and exit
    #2;
    rst2_n = 1'b0;
    rst1_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset ready c%0d", i), 32'(ready2), 32'd0);
      check($sformatf("reset valid c%0d", i), 32'(valid2), 32'd0);
      check($sformatf("reset rdata c%0d", i), read_data2, 32'd0);
    end
    check("reset ready lat1", 32'(ready1), 32'd0);
    rst2_n = 1'b1;
    rst1_n = 1'b1;
    #1;
    check("rst_exit ready before edge", 32'(ready2), 32'd0);
    tick();
    check("ready after exit", 32'(ready2), 32'd1);
    check("ready after exit lat1", 32'(ready1), 32'd1);
    check("valid after exit", 32'(valid2), 32'd0);

    // Word write then read
    txn(0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, "word write 0x10");
    txn(0, 1'b0, 1'b0, 32'h10, 32'h0, "word read 0x10");
    check("word read const", read_data2, 32'hDEAD_BEEF);

    // Byte ops
    txn(0, 1'b1, 1'b1, 32'h11, 32'hFFFF_FF5A, "byte write 0x11");
    txn(0, 1'b0, 1'b0, 32'h10, 32'h0, "word read after byte write");
    check("merged word const", read_data2, 32'hDEAD_5AEF);
    txn(0, 1'b0, 1'b1, 32'h13, 32'h0, "byte read 0x13");
    check("byte read const", read_data2, 32'h0000_00DE);

    // Back-pressure: req held high, busy-time inputs are hostile writes that must be ignored
    exp = model_read(0, 1'b0, 32'h10);
    for (int i = 0; i < 9; i++) begin
      if (i % 3 == 0) begin
        we = 1'b0; byte_op = 1'b0; addr = 32'h10;
      end else begin
        we = 1'b1; byte_op = 1'b0; addr = 32'h10; wdata = 32'hFFFF_FFFF;
      end
      req2 = 1'b1;
      check($sformatf("bp ready c%0d", i), 32'(ready2), 32'(i % 3 == 0));
      check($sformatf("bp valid c%0d", i), 32'(valid2), 32'(i % 3 == 2));
      if (i % 3 == 2) check($sformatf("bp rdata c%0d", i), read_data2, exp);
      tick();
    end
    req2 = 1'b0;
    txn(0, 1'b0, 1'b0, 32'h10, 32'h0, "read after back-pressure");

    // Reset during WAIT aborts the write
    we = 1'b1; byte_op = 1'b0; addr = 32'h20; wdata = 32'h1234_5678;
    req2 = 1'b1;
    tick();
    req2 = 1'b0;
    check("abort accepted", 32'(ready2), 32'd0);
    rst2_n = 1'b0;
    #1;
    check("abort valid in reset", 32'(valid2), 32'd0);
    check("abort rdata in reset", read_data2, 32'd0);
    tick();
    check("abort valid held reset", 32'(valid2), 32'd0);
    rst2_n = 1'b1;
    #1;
    check("abort ready rst_exit", 32'(ready2), 32'd0);
    tick();
    check("abort ready idle", 32'(ready2), 32'd1);
    check("abort no spurious valid", 32'(valid2), 32'd0);
    txn(0, 1'b0, 1'b0, 32'h20, 32'h0, "read aborted 0x20");
    check("aborted word const", read_data2, 32'd0);

    // Latency 1 and address aliasing
    txn(1, 1'b1, 1'b0, 32'h404, 32'hCAFE_F00D, "lat1 write 0x404");
    txn(1, 1'b0, 1'b0, 32'h004, 32'h0, "lat1 read 0x004");
    check("alias const", read_data1, 32'hCAFE_F00D);

    // Randomized traffic including unaligned word ops and high-address aliases
    for (int n = 0; n < 40; n++) begin
      rwe = 1'($urandom_range(0, 1));
      rbo = 1'($urandom_range(0, 1));
      ra = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
      txn(0, rwe, rbo, ra, $urandom, $sformatf("rand2 n%0d", n));
      repeat ($urandom_range(0, 2)) tick();
    end
    for (int n = 0; n < 12; n++) begin
      rwe = 1'($urandom_range(0, 1));
      rbo = 1'($urandom_range(0, 1));
      ra = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 15));
      txn(1, rwe, rbo, ra, $urandom, $sformatf("rand1 n%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
